// File: rtl/sign_narrow_if.sv
// rtl/sign_narrow_if.sv - valid/ready sample stream bundle for the signed narrowing stage
interface sign_narrow_if #(
    parameter int FROM_WIDTH = 32,
    parameter int TO_WIDTH   = 12
);
    logic [FROM_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [TO_WIDTH-1:0]   out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sat;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sat
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sat
    );
endinterface

// File: rtl/sign_narrow.sv
// rtl/sign_narrow.sv - saturating signed narrowing stage with skid buffer and saturation counter
module sign_narrow #(
    parameter int FROM_WIDTH = 32,
    parameter int TO_WIDTH   = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sign_narrow_if.slave         s,
    input  logic                 clr_cnt,
    output logic [CNT_WIDTH-1:0] sat_cnt
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [FROM_WIDTH-TO_WIDTH:0] upper;
    logic                         fits;
    logic [TO_WIDTH-1:0]          nar_data;
    logic                         nar_sat;

    logic [TO_WIDTH-1:0] out_data_q, skid_data_q;
    logic                out_sat_q, skid_sat_q;
    logic                in_ready_w, out_valid_w;
    logic                accept, deliver;
    logic                load_out, load_skid, move_skid;

    // The value fits when every bit from the target sign bit upward agrees.
    always_comb begin
        upper   = s.in_data[FROM_WIDTH-1:TO_WIDTH-1];
        fits    = (&upper) | ~(|upper);
        nar_sat = ~fits;
        if (fits)
            nar_data = s.in_data[TO_WIDTH-1:0];
        else if (s.in_data[FROM_WIDTH-1])
            nar_data = {1'b1, {(TO_WIDTH-1){1'b0}}};
        else
            nar_data = {1'b0, {(TO_WIDTH-1){1'b1}}};
    end

    assign in_ready_w  = (state != ST_FULL);
    assign out_valid_w = (state != ST_EMPTY);
    assign accept      = s.in_valid && in_ready_w;
    assign deliver     = out_valid_w && s.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_out  = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (deliver && accept) begin
                    load_out = 1'b1;
                end else if (deliver) begin
                    state_nxt = ST_EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    move_skid = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            skid_data_q <= '0;
            skid_sat_q  <= 1'b0;
        end else begin
            if (load_out) begin
                out_data_q <= nar_data;
                out_sat_q  <= nar_sat;
            end else if (move_skid) begin
                out_data_q <= skid_data_q;
                out_sat_q  <= skid_sat_q;
            end
            if (load_skid) begin
                skid_data_q <= nar_data;
                skid_sat_q  <= nar_sat;
            end
        end
    end

    // A clear coinciding with a saturated delivery still counts that delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_cnt <= '0;
        else if (clr_cnt)
            sat_cnt <= (deliver && out_sat_q) ? CNT_WIDTH'(1) : '0;
        else if (deliver && out_sat_q && !(&sat_cnt))
            sat_cnt <= sat_cnt + 1'b1;
    end

    assign s.in_ready  = in_ready_w;
    assign s.out_valid = out_valid_w;
    assign s.out_data  = out_data_q;
    assign s.out_sat   = out_sat_q;
endmodule
